// File: rtl/rv32m_iter_divider.sv
// Purpose : RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per clock.
// Latency : div_stall high 33 cycles (normal) or 1 cycle (divide-by-zero / signed overflow),
//           then done=1 for one cycle, or for as long as hold=1 (result held stable).
// Ports   : clk, rst_n | start, funct3, op_a, op_b, flush, hold (from EX / hazard unit)
//           | div_stall (freezes F/D/E), result, done (registered; result=0 unless done).
module rv32m_iter_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    input  logic        hold,
    output logic        div_stall,
    output logic [31:0] result,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;      // partial remainder
    logic [31:0] quo_q, quo_d;      // dividend shifting out, quotient shifting in
    logic [31:0] dvs_q, dvs_d;      // |divisor|
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        sel_rem_q, sel_rem_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    // Launch decode on the raw EX inputs.
    // MUL-class encodings (funct3[2]=0) never start a divide, even if start is raised.
    logic        div_op;
    logic        is_signed;
    logic        div_zero;
    logic        sig_ovf;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] sp_quo;
    logic [31:0] sp_rem;

    assign div_op    = start & funct3[2];
    assign is_signed = ~funct3[0];
    assign div_zero  = (op_b == 32'd0);
    assign sig_ovf   = is_signed & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
    assign abs_a     = (is_signed & op_a[31]) ? (32'd0 - op_a) : op_a;
    assign abs_b     = (is_signed & op_b[31]) ? (32'd0 - op_b) : op_b;
    assign sp_quo    = div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
    assign sp_rem    = div_zero ? op_a : 32'd0;

    // One restoring step. The shifted remainder is below 2*divisor, so the
    // 33-bit difference's top bit is a reliable "went negative" flag.
    logic [32:0] r_shift;
    logic [32:0] diff;
    logic [31:0] iter_rem;
    logic [31:0] iter_quo;
    logic [31:0] fin_quo;
    logic [31:0] fin_rem;

    assign r_shift  = {rem_q, quo_q[31]};
    assign diff     = r_shift - {1'b0, dvs_q};
    assign iter_rem = diff[32] ? r_shift[31:0] : diff[31:0];
    assign iter_quo = {quo_q[30:0], ~diff[32]};
    assign fin_quo  = neg_quo_q ? (32'd0 - iter_quo) : iter_quo;
    assign fin_rem  = neg_rem_q ? (32'd0 - iter_rem) : iter_rem;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        sel_rem_d = sel_rem_q;
        result_d  = 32'd0;
        done_d    = 1'b0;
        div_stall = 1'b0;

        case (state_q)
            IDLE: begin
                if (div_op && !flush) begin
                    div_stall = 1'b1;
                    sel_rem_d = funct3[1];
                    if (div_zero || sig_ovf) begin
                        // Result is known now; skip the iterations entirely.
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = funct3[1] ? sp_rem : sp_quo;
                    end else begin
                        state_d   = BUSY;
                        cnt_d     = 6'd0;
                        rem_d     = 32'd0;
                        quo_d     = abs_a;
                        dvs_d     = abs_b;
                        neg_quo_d = is_signed & (op_a[31] ^ op_b[31]);
                        neg_rem_d = is_signed & op_a[31];
                    end
                end
            end

            BUSY: begin
                div_stall = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = iter_rem;
                    quo_d = iter_quo;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        result_d = sel_rem_q ? fin_rem : fin_quo;
                    end
                end
            end

            DONE: begin
                // start is deliberately ignored here: EX still presents the
                // finishing instruction until it advances.
                if (flush) begin
                    state_d = IDLE;
                end else if (hold) begin
                    done_d   = 1'b1;
                    result_d = result_q;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            sel_rem_q <= 1'b0;
            result_q  <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            sel_rem_q <= sel_rem_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rv32m_iter_divider.sv
// Purpose : self-checking bench for rv32m_iter_divider (scoreboard + reference model).
// Latency : expects 33 stall cycles for normal ops, 1 for special cases.
// Ports   : drives start/funct3/op_a/op_b/flush/hold like an EX stage; monitor checks at negedge.
module tb_rv32m_iter_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b100;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic        div_stall;
    logic [31:0] result;
    logic        done;

    rv32m_iter_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .hold      (hold),
        .div_stall (div_stall),
        .result    (result),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain integer arithmetic plus the architectural special cases.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        int          sa;
        int          sb;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (f3[0]) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = a;
            sb = b;
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
        return f3[1] ? r : q;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Monitor: measures the stall run preceding each done, checks result
    // against the scoreboard, checks hold stability and result=0 outside done.
    int          run = 0;
    int          cap_run = 0;
    bit          in_done = 1'b0;
    logic [31:0] first_res = 32'd0;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            run     = 0;
            in_done = 1'b0;
        end else if (div_stall) begin
            run++;
            chk("done_during_stall", 32'(done), 32'd0);
        end else if (done) begin
            if (!in_done) begin
                in_done   = 1'b1;
                cap_run   = run;
                first_res = result;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", result, e.res);
                    chk("stall_latency", 32'(cap_run), 32'(e.lat));
                end
            end else begin
                chk("result_stable_hold", result, first_res);
            end
            if (!hold) begin
                in_done = 1'b0;
                run     = 0;
            end
        end else begin
            run = 0;
            chk("result_zero_idle", result, 32'd0);
        end
    end

    // EX-stage model: raise start, wait for done, hold for nh cycles, consume.
    // Leaves start high on return; caller launches the next op or drops start.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input int el, input int nh,
                          output int done_cyc);
        int guard = 0;
        int ndone = 0;
        int nh_left = nh;
        bit got = 1'b0;
        exp_t x;
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        hold   = 1'b0;
        x.res  = er;
        x.lat  = el;
        exp_q.push_back(x);
        done_cyc = -1;
        forever begin
            @(posedge clk); #1;
            guard++;
            if (done) begin
                if (!got) begin
                    got      = 1'b1;
                    done_cyc = cyc;
                end
                ndone++;
                if (nh_left > 0) begin
                    hold = 1'b1;
                    nh_left--;
                end else begin
                    hold = 1'b0;
                    @(posedge clk); #1;
                    break;
                end
            end
            if (guard > 100) begin
                chk("op_timeout", 32'(done), 32'd1);
                break;
            end
        end
        chk("done_cycles", 32'(ndone), 32'(nh + 1));
    endtask

    task automatic idle_cycles(input int n);
        start = 1'b0;
        hold  = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int dc1;
    int dc2;
    int dummy;

    initial begin
        // Reset state
        #12;
        chk("rst_div_stall", 32'(div_stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors with known answers
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 33, 0, dummy);
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 33, 0, dummy);
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, dummy);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, dummy);
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0, dummy);
        run_op(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, dummy);
        run_op(3'b111, 32'd5, 32'd0, 32'd5, 1, 0, dummy);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, dummy);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, dummy);
        idle_cycles(2);

        // Flush during BUSY iteration 10
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'hDEAD_BEEF;
        op_b   = 32'd13;
        repeat (11) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_stall", 32'(div_stall), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        idle_cycles(3);
        chk("flush_no_done", 32'(done), 32'd0);
        run_op(3'b101, 32'd9, 32'd3, 32'd3, 33, 0, dummy);

        // Hold for 4 cycles in DONE
        run_op(3'b101, 32'd1000, 32'd9, 32'd111, 33, 4, dummy);
        chk("hold_then_idle_done", 32'(done), 32'd0);
        idle_cycles(2);

        // Back-to-back: done pulses 34 cycles apart, no relaunch of the first op
        run_op(3'b101, 32'd20, 32'd4, 32'd5, 33, 0, dc1);
        run_op(3'b101, 32'd21, 32'd4, 32'd5, 33, 0, dc2);
        chk("b2b_spacing", 32'(dc2 - dc1), 32'd34);
        idle_cycles(40);

        // Asynchronous reset mid-BUSY
        start  = 1'b1;
        funct3 = 3'b101;
        op_a   = 32'd12345;
        op_b   = 32'd7;
        repeat (6) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("arst_stall", 32'(div_stall), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", result, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(3'b101, 32'd9, 32'd3, 32'd3, 33, 0, dummy);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            int          nh;
            f3 = {1'b1, 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'($urandom_range(0, 50));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                3:       b = 32'd0 - 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            nh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(f3, a, b, ref_result(f3, a, b), ref_lat(f3, a, b), nh, dummy);
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(5);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rv32m_iter_divider.md
RV32M_ITER_DIVIDER -- requirements
Module: rv32m_iter_divider

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports ordered as listed below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  EX-stage divide/remainder op is valid; held stable by EX while div_stall is high.
REQ-005 funct3  input  3  operation select: 100 DIV, 101 DIVU, 110 REM, 111 REMU; sampled with start.
REQ-006 op_a  input  32  dividend (rs1 after forwarding); sampled with start.
REQ-007 op_b  input  32  divisor (rs2 after forwarding); sampled with start.
REQ-008 flush  input  1  abort the in-flight op.
REQ-009 hold  input  1  pipeline frozen by a memory stall; the DONE result is not yet consumed.
REQ-010 div_stall  output  1  drives the hazard unit's DivStalled input and freezes F, D and E.
REQ-011 result  output  32  quotient or remainder; valid while done=1.
REQ-012 done  output  1  result valid; EX advances when done=1 and hold=0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 In IDLE with start=1 and flush=0, the block SHALL latch operands and funct3, assert div_stall in that same cycle (combinational), and go to BUSY. If the op is a special case, it SHALL go to DONE instead.
REQ-015 Special cases SHALL be: op_b=0, and signed overflow (DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF).
REQ-016 BUSY SHALL run 32 radix-2 restoring iterations using a 6-bit counter, one iteration per clock, then go to DONE.
REQ-017 div_stall SHALL equal (IDLE & start & ~flush) | BUSY; it SHALL be 0 in DONE.
REQ-018 Stall latency SHALL be 33 cycles for the normal path and 1 cycle for special cases; done SHALL assert in the cycle after div_stall falls.
REQ-019 Signed ops SHALL divide absolute values as unsigned numbers. The quotient SHALL be negated when the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-020 Divide by zero SHALL give quotient 0xFFFFFFFF and remainder = op_a, for both signed and unsigned ops.
REQ-021 Signed overflow SHALL give quotient 0x80000000 and remainder 0.
REQ-022 result SHALL select the quotient for funct3[1]=0 and the remainder for funct3[1]=1; all arithmetic SHALL be 32-bit modulo 2^32.
REQ-023 DONE SHALL persist while hold=1, with result stable; with hold=0 it SHALL last exactly one cycle, then go to IDLE.
REQ-024 The block SHALL NOT relaunch the same instruction: start is ignored in DONE, and IDLE is only re-entered after EX advances.
REQ-025 Back-to-back divides SHALL be accepted: a new start in IDLE the cycle after DONE begins a new op.
REQ-026 flush=1 in any state SHALL force IDLE on the next edge, with done=0 and div_stall=0 from the next cycle. flush takes priority over start, over hold and over iteration completion.
REQ-027 done and result SHALL be registered outputs; result SHALL be 0 outside DONE.

Reset
REQ-028 While rst_n=0, the block SHALL force state=IDLE, div_stall=0, done=0, result=0, counter=0 and all datapath registers to 0, asynchronously and including mid-BUSY.
REQ-029 After rst_n rises, the first start SHALL be honoured on the next clock edge.

Verification
REQ-030 DIVU 100/7: div_stall high 33 cycles, then done=1 with result=14 for one cycle; REMU on the same operands gives result=2.
REQ-031 DIV 0xFFFFFFF9(-7)/2 gives result=0xFFFFFFFD(-3); REM -7/2 gives 0xFFFFFFFF(-1); REM 7/0xFFFFFFFE gives 1.
REQ-032 DIV 5/0 gives 0xFFFFFFFF after 1 stall cycle; REMU 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM on the same operands gives 0, each after 1 stall cycle.
REQ-033 flush=1 in BUSY iteration 10: IDLE next cycle, div_stall=0, no done pulse; a subsequent DIVU 9/3 gives 3.
REQ-034 hold=1 for 4 cycles during DONE: done and result stay stable for 5 cycles, then IDLE; rst_n=0 mid-BUSY: all outputs 0 immediately.
REQ-035 Two DIVU ops back-to-back (20/4, then 21/4): done pulses 34 cycles apart, with results 5 and 5, and no duplicate launch of the first op.
